up_state_ctrl: RTL and testbench

//  uP-level run-state sequencer sitting directly upstream of the core. Holds the core in reset-like

---
 rtl/up_state_ctrl.sv | 171 +++++++++++++++++
 tb/tb_up_state_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/up_state_ctrl.sv
// up_state_ctrl
//   Run-state sequencer for the core. Holds the core in BOOT until the boot
//   loader reports the image is loaded, then lets it run. A debounced pause
//   button press, or a core HLT, starts a pause handshake: start-pause is
//   raised, the sequencer waits for the core's now-paused confirmation (or a
//   timeout, which sets a sticky fault), and the next button press resumes.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst             synchronous reset, active-high
//   i_bootDone        boot loader finished (sampled only in BOOT)
//   i_pauseBtn        raw asynchronous pause/resume button, active-high
//   i_coreHLT         core executed HLT
//   i_coreNowPaused   core confirms it is paused
//   o_smIsBooted      core may run (every state except BOOT)
//   o_smStartPause    pause request to the core (PAUSING and PAUSED)
//   o_state           00 BOOT, 01 RUN, 10 PAUSING, 11 PAUSED
//   o_fault           sticky pause-handshake timeout flag
//
// state   | meaning
// --------+----------------------------------------------------------
// BOOT    | core held off, waiting for i_bootDone
// RUN     | core running, watching for press or HLT
// PAUSING | start-pause driven, waiting for now-paused or timeout
// PAUSED  | core paused, start-pause held, waiting for a resume press

module up_state_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  PAUSE_TIMEOUT   = 8'd64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bootDone,
  input  logic       i_pauseBtn,
  input  logic       i_coreHLT,
  input  logic       i_coreNowPaused,
  output logic       o_smIsBooted,
  output logic       o_smStartPause,
  output logic [1:0] o_state,
  output logic       o_fault
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSING = 2'b10,
    ST_PAUSED  = 2'b11
  } state_t;

  localparam logic [15:0] DB_TC = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [7:0]  TO_TC = PAUSE_TIMEOUT - 8'd1;

  // ---------------------------------------------------------------------
  // Button synchroniser
  // ---------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pauseBtn;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer: the synced level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is taken. Any return to
  // the accepted level restarts the count. Only a 0->1 acceptance makes a
  // press; the pulse is registered so the FSM sees it one cycle later.
  // ---------------------------------------------------------------------
  logic        r_btn_stable;
  logic [15:0] r_db_cnt;
  logic        r_press;
  logic        w_press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_stable <= 1'b0;
      r_db_cnt     <= 16'd0;
      r_press      <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_btn_stable) begin
        r_db_cnt <= 16'd0;
      end else if (r_db_cnt >= DB_TC) begin
        r_btn_stable <= r_sync2;
        r_db_cnt     <= 16'd0;
        r_press      <= r_sync2;
      end else if (r_db_cnt != 16'hFFFF) begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  assign w_press = r_press;

  // ---------------------------------------------------------------------
  // Run-state FSM. Outputs are registered alongside the state so they are
  // glitch-free and change on the same edge as o_state.
  // ---------------------------------------------------------------------
  state_t     r_state;
  logic       r_is_booted;
  logic       r_start_pause;
  logic       r_fault;
  logic [7:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_BOOT;
      r_is_booted   <= 1'b0;
      r_start_pause <= 1'b0;
      r_fault       <= 1'b0;
      r_to_cnt      <= 8'd0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          // presses arriving here are simply not looked at
          if (i_bootDone) begin
            r_state     <= ST_RUN;
            r_is_booted <= 1'b1;
          end
        end

        ST_RUN: begin
          r_to_cnt <= 8'd0;
          if (w_press || i_coreHLT) begin
            r_state       <= ST_PAUSING;
            r_start_pause <= 1'b1;
          end
        end

        ST_PAUSING: begin
          // the timeout compares the current count, so PAUSING lasts at
          // most PAUSE_TIMEOUT cycles before the fault path forces PAUSED
          if (i_coreNowPaused) begin
            r_state <= ST_PAUSED;
          end else if (r_to_cnt >= TO_TC) begin
            r_fault <= 1'b1;
            r_state <= ST_PAUSED;
          end else if (r_to_cnt != 8'hFF) begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end

        ST_PAUSED: begin
          // start-pause stays high here; the core pause is a copy of it
          if (w_press) begin
            r_state       <= ST_RUN;
            r_start_pause <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_BOOT;
          r_is_booted   <= 1'b0;
          r_start_pause <= 1'b0;
        end
      endcase
    end
  end

  assign o_state        = r_state;
  assign o_smIsBooted   = r_is_booted;
  assign o_smStartPause = r_start_pause;
  assign o_fault        = r_fault;

endmodule

// File: tb/tb_up_state_ctrl.sv
module tb_up_state_ctrl;

  logic       clk;
  logic       rst;
  logic       boot_done;
  logic       pause_btn;
  logic       core_hlt;
  logic       core_now_paused;
  logic       is_booted;
  logic       start_pause;
  logic [1:0] state;
  logic       fault;

  int n_pass  = 0;
  int n_total = 0;

  up_state_ctrl #(
    .DEBOUNCE_CYCLES(16'd8),
    .PAUSE_TIMEOUT  (8'd4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_bootDone     (boot_done),
    .i_pauseBtn     (pause_btn),
    .i_coreHLT      (core_hlt),
    .i_coreNowPaused(core_now_paused),
    .o_smIsBooted   (is_booted),
    .o_smStartPause (start_pause),
    .o_state        (state),
    .o_fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       boot;
    logic       hlt;
    logic       np;
    logic [1:0] st;
    logic       booted;
    logic       sp;
    logic       flt;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input int st, input int bo, input int sp, input int fl);
    chk({nm, " state"},  int'(state),       st);
    chk({nm, " booted"}, int'(is_booted),   bo);
    chk({nm, " spause"}, int'(start_pause), sp);
    chk({nm, " fault"},  int'(fault),       fl);
  endtask

  initial begin
    //            rst boot hlt np   st    bo  sp  flt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; boot_done = 1'b0; pause_btn = 1'b0;
    core_hlt = 1'b0; core_now_paused = 1'b0;

    // stays in BOOT without bootDone
    tick();
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    ticks(20);
    chk_all("boot_wait", 0, 0, 0, 0);

    // table: boot, HLT handshake, HLT ignored in PAUSED, timeout fault
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; boot_done = vecs[i].boot;
      core_hlt = vecs[i].hlt; core_now_paused = vecs[i].np;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].booted),
              int'(vecs[i].sp), int'(vecs[i].flt));
    end
    rst = 1'b0; boot_done = 1'b0; core_hlt = 1'b0; core_now_paused = 1'b0;

    // press accepted while in BOOT is dropped
    pause_btn = 1'b1; ticks(14);
    pause_btn = 1'b0; ticks(14);
    chk("boot_press state", int'(state), 0);
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    chk("boot_exit state", int'(state), 1);
    ticks(15);
    chk("boot_press_lost state", int'(state), 1);

    // 5-cycle glitch is rejected
    pause_btn = 1'b1; ticks(5);
    pause_btn = 1'b0; ticks(20);
    chk("glitch state", int'(state), 1);

    // held press: RUN -> PAUSING after 11 edges, exactly once
    pause_btn = 1'b1; ticks(10);
    chk("press_lat10 state", int'(state), 1);
    tick();
    chk_all("press_lat11", 2, 1, 1, 0);
    core_now_paused = 1'b1; tick(); core_now_paused = 1'b0;
    chk("press_paused state", int'(state), 3);
    ticks(8);
    pause_btn = 1'b0; ticks(15);
    chk_all("press_release", 3, 1, 1, 0);

    // resume from PAUSED, then re-pause
    pause_btn = 1'b1; ticks(10);
    chk("resume_lat10 state", int'(state), 3);
    tick();
    chk_all("resume", 1, 1, 0, 0);
    pause_btn = 1'b0; ticks(15);
    chk("resume_release state", int'(state), 1);
    pause_btn = 1'b1; ticks(11);
    chk("repress state", int'(state), 2);
    core_now_paused = 1'b1; tick(); core_now_paused = 1'b0;
    chk("repress_paused state", int'(state), 3);
    pause_btn = 1'b0; ticks(12);

    // reset in PAUSED with a debounce in progress
    pause_btn = 1'b1; ticks(5);
    rst = 1'b1; pause_btn = 1'b0; tick();
    chk_all("mid_reset", 0, 0, 0, 0);
    rst = 1'b0; boot_done = 1'b1; tick(); boot_done = 1'b0;
    chk("post_reset_boot state", int'(state), 1);
    ticks(15);
    chk_all("pending_lost", 1, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
